hcsr04_emu: RTL

HCSR04_EMU -- requirements
Module: hcsr04_emu

---
 rtl/hcsr04_emu.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/hcsr04_emu.sv
// -----------------------------------------------------------------------------
// hcsr04_emu
//
// Emulates an HC-SR04 ultrasonic ranging sensor. A ranging controller raises
// sig_trig for at least MIN_TRIG_US; when the trigger falls the emulator waits
// BURST_US (the ultrasonic burst time of the real sensor), then drives sig_len
// high for the programmed echo width, then stays busy for HOLDOFF_US before it
// accepts another trigger.
//
// Ports
//   clk50M      in   single system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   sig_trig    in   trigger from the ranging controller, asynchronous
//   echo_us     in   [15:0] echo width in us, 0 = no object (TIMEOUT_US used)
//   sig_len     out  echo pulse, registered
//   busy        out  high whenever the emulator is not idle
//   short_trig  out  one-cycle pulse: trigger rejected as too short
//   echo_done   out  one-cycle pulse on the cycle sig_len falls
// -----------------------------------------------------------------------------
module hcsr04_emu #(
    parameter int CYC_PER_US  = 50,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic        clk50M,
    input  logic        rst,
    input  logic        sig_trig,
    input  logic [15:0] echo_us,
    output logic        sig_len,
    output logic        busy,
    output logic        short_trig,
    output logic        echo_done
);

    // -------------------------------------------------------------------------
    // Derived cycle counts and counter widths
    // -------------------------------------------------------------------------
    localparam int TRIG_CYC  = MIN_TRIG_US * CYC_PER_US;
    localparam int BURST_CYC = BURST_US * CYC_PER_US;
    localparam int HOLD_CYC  = HOLDOFF_US * CYC_PER_US;

    localparam int MAX_AB  = (TRIG_CYC > BURST_CYC) ? TRIG_CYC : BURST_CYC;
    localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] TRIG_SAT   = CNT_W'(TRIG_CYC);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // The echo width is counted as a 6-bit us prescaler plus a 16-bit us
    // counter, giving 65535 us at up to 64 cycles/us without overflow.
    localparam logic [5:0]  PRE_LAST    = 6'(CYC_PER_US - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_US);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRIG  = 3'd1,
        BURST = 3'd2,
        ECHO  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;         // shared by TRIG, BURST and HOLD
    logic [5:0]        pre;         // ECHO: cycles within the current us
    logic [15:0]       us_cnt;      // ECHO: whole us elapsed
    logic [15:0]       latched_us;  // echo width frozen at trigger acceptance

    logic              sync1;
    logic              trig_s;
    logic              trig_d;
    logic [1:0]        settle;
    logic              armed;
    logic              trig_rise;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Trigger-high counter, saturating at the minimum valid length so that a
    // trigger held arbitrarily long never wraps into looking short.
    function automatic logic [CNT_W-1:0] trig_inc(input logic [CNT_W-1:0] c);
        return (c == TRIG_SAT) ? c : c + CNT_ONE;
    endfunction

    // Echo width to use for a new measurement: 0 means "no object", which a
    // real sensor reports as its maximum (timeout) echo.
    function automatic logic [15:0] echo_target(input logic [15:0] us);
        return (us == 16'd0) ? TIMEOUT_VAL : us;
    endfunction

    // -------------------------------------------------------------------------
    // Trigger synchronizer and edge detector
    // -------------------------------------------------------------------------
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            sync1  <= sig_trig;
            trig_s <= sync1;
            trig_d <= trig_s;
        end
    end

    // -------------------------------------------------------------------------
    // Post-reset arming
    //
    // The synchronizer flops reset to 0, so a trigger already high when reset
    // is released would appear as a fresh rising edge. Edges are accepted only
    // once the synchronizer has refilled (settle reaches 3) and trig_s has
    // actually been seen low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd3)
                settle <= settle + 2'd1;
            if (settle == 2'd3 && !trig_s)
                armed <= 1'b1;
        end
    end

    assign trig_rise = trig_s & ~trig_d & armed;

    // -------------------------------------------------------------------------
    // Main state machine
    //
    // Timing from the first edge E0 that samples sig_trig low:
    //   E0+1  trig_s low
    //   E0+2  TRIG sees trig_s low -> BURST
    //   +BURST_CYC edges in BURST   -> ECHO
    //   first ECHO edge raises sig_len, giving BURST_CYC+3 overall.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pre        <= 6'd0;
            us_cnt     <= 16'd0;
            latched_us <= 16'd0;
            sig_len    <= 1'b0;
            busy       <= 1'b0;
            short_trig <= 1'b0;
            echo_done  <= 1'b0;
        end else begin
            short_trig <= 1'b0;
            echo_done  <= 1'b0;

            case (state)
                IDLE: begin
                    sig_len <= 1'b0;
                    if (trig_rise) begin
                        // The edge cycle itself already has trig_s high.
                        state <= TRIG;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end

                TRIG: begin
                    if (trig_s) begin
                        cnt <= trig_inc(cnt);
                    end else if (cnt == TRIG_SAT) begin
                        state      <= BURST;
                        cnt        <= '0;
                        latched_us <= echo_target(echo_us);
                    end else begin
                        state      <= IDLE;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        short_trig <= 1'b1;
                    end
                end

                BURST: begin
                    if (cnt == BURST_LAST) begin
                        state  <= ECHO;
                        cnt    <= '0;
                        pre    <= 6'd0;
                        us_cnt <= 16'd0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ECHO: begin
                    // us_cnt*CYC_PER_US + pre equals the number of ECHO edges
                    // already taken; sig_len rose on the first of them, so the
                    // pulse is complete when that total reaches the width.
                    // latched_us is never 0, so the first edge cannot end it.
                    if (us_cnt == latched_us && pre == 6'd0) begin
                        state     <= HOLD;
                        sig_len   <= 1'b0;
                        echo_done <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        sig_len <= 1'b1;
                        if (pre == PRE_LAST) begin
                            pre    <= 6'd0;
                            us_cnt <= us_cnt + 16'd1;
                        end else begin
                            pre <= pre + 6'd1;
                        end
                    end
                end

                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    sig_len <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
